// File: rtl/axis_skid_pkg.sv
// axis_skid_pkg
// Shared definitions for the AXI Stream skid buffer slice:
//   skid_state_t - occupancy of the two beat registers
//   beat_width() - width of one packed beat {tdata, tkeep, tuser, tid, tdest, tlast}
package axis_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  function automatic int beat_width(input int data_w, input int user_w,
                                    input int id_w, input int dest_w);
    return data_w + data_w / 8 + user_w + id_w + dest_w + 1;
  endfunction

endpackage

// File: rtl/axis_pkt_counter.sv
// axis_pkt_counter
// 32-bit statistics counter that wraps from 0xFFFFFFFF to 0.
// Ports:
//   aclk    - clock
//   areset  - synchronous active-high reset, clears the count
//   inc     - count one event this cycle
//   count   - current count, registered
module axis_pkt_counter (
  input  logic        aclk,
  input  logic        areset,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      count_q <= 32'd0;
    end else if (inc) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/axi_stream_skid_buffer.sv
// axi_stream_skid_buffer
// Two-entry AXI Stream skid buffer. Every output, including axis_in_tready,
// comes straight from a flop, so no combinational path crosses the block.
// Sustains one beat per cycle while the consumer is ready.
// Ports:
//   aclk, areset          - clock, synchronous active-high reset
//   axis_in_*             - upstream beat (tdata/tkeep/tuser/tid/tdest/tlast), tvalid, tready out
//   axis_out_*            - downstream beat, tvalid out, tready in
//   stat_pkt_count        - packets forwarded (only when AXIS_SKID_PKT_COUNT_EN is defined)
// Build option: define AXIS_SKID_PKT_COUNT_EN to add the packet counter and its port.
module axi_stream_skid_buffer
  import axis_skid_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH   = 64,
  parameter int AXIS_TID_WIDTH   = 1,
  parameter int AXIS_TDEST_WIDTH = 1,
  parameter int AXIS_TUSER_WIDTH = 1
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXIS_BUS_WIDTH-1:0]   axis_in_tdata,
  input  logic [AXIS_BUS_WIDTH/8-1:0] axis_in_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0] axis_in_tuser,
  input  logic [AXIS_TID_WIDTH-1:0]   axis_in_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0] axis_in_tdest,
  input  logic                        axis_in_tlast,
  input  logic                        axis_in_tvalid,
  output logic                        axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]   axis_out_tdata,
  output logic [AXIS_BUS_WIDTH/8-1:0] axis_out_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0] axis_out_tuser,
  output logic [AXIS_TID_WIDTH-1:0]   axis_out_tid,
  output logic [AXIS_TDEST_WIDTH-1:0] axis_out_tdest,
  output logic                        axis_out_tlast,
  output logic                        axis_out_tvalid,
  input  logic                        axis_out_tready
`ifdef AXIS_SKID_PKT_COUNT_EN
  ,
  output logic [31:0]                 stat_pkt_count
`endif
);

  localparam int BEAT_W = beat_width(AXIS_BUS_WIDTH, AXIS_TUSER_WIDTH,
                                     AXIS_TID_WIDTH, AXIS_TDEST_WIDTH);

  skid_state_t       state_p1;
  skid_state_t       state_nxt;
  logic [BEAT_W-1:0] beat_p0;
  logic [BEAT_W-1:0] oreg_p1;
  logic [BEAT_W-1:0] sreg_p1;
  logic              vld_p1;
  logic              rdy_p1;
  logic              in_xfer;
  logic              out_xfer;
  logic              load_oreg_in;
  logic              load_oreg_skid;
  logic              load_sreg;

  // Stage p0: incoming beat packed as one vector
  assign beat_p0 = {axis_in_tdata, axis_in_tkeep, axis_in_tuser,
                    axis_in_tid, axis_in_tdest, axis_in_tlast};

  assign in_xfer  = axis_in_tvalid & rdy_p1;
  assign out_xfer = vld_p1 & axis_out_tready;

  always_comb begin
    state_nxt      = state_p1;
    load_oreg_in   = 1'b0;
    load_oreg_skid = 1'b0;
    load_sreg      = 1'b0;
    case (state_p1)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt    = BUSY;
          load_oreg_in = 1'b1;
        end
      end
      BUSY: begin
        if (in_xfer && !out_xfer) begin
          state_nxt = FULL;
          load_sreg = 1'b1;
        end else if (in_xfer && out_xfer) begin
          load_oreg_in = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // rdy_p1 is low here, so only the drain side can move
        if (out_xfer) begin
          state_nxt      = BUSY;
          load_oreg_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Stage p1: control flops; valid and ready are registered from the next state
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_p1 <= EMPTY;
      vld_p1   <= 1'b0;
      rdy_p1   <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      vld_p1   <= (state_nxt != EMPTY);
      rdy_p1   <= (state_nxt != FULL);
    end
  end

  // Stage p1: beat storage, never reset (contents are meaningless while invalid)
  always_ff @(posedge aclk) begin
    if (load_oreg_in) begin
      oreg_p1 <= beat_p0;
    end else if (load_oreg_skid) begin
      oreg_p1 <= sreg_p1;
    end
    if (load_sreg) begin
      sreg_p1 <= beat_p0;
    end
  end

  assign {axis_out_tdata, axis_out_tkeep, axis_out_tuser,
          axis_out_tid, axis_out_tdest, axis_out_tlast} = oreg_p1;
  assign axis_out_tvalid = vld_p1;
  assign axis_in_tready  = rdy_p1;

`ifdef AXIS_SKID_PKT_COUNT_EN
  axis_pkt_counter u_pkt_counter (
    .aclk   (aclk),
    .areset (areset),
    .inc    (out_xfer & axis_out_tlast),
    .count  (stat_pkt_count)
  );
`endif

endmodule
